// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives a synchronous-read ROM, tracks one in-flight
// read, and buffers returned words in a 2-entry skid FIFO toward decode.
module fetch_unit #(
  parameter int DATA_LENGTH = 32,
  parameter int MEM_LENGTH  = 32,
  parameter int RESET_PC    = 0,
  localparam int AW         = $clog2(MEM_LENGTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [AW-1:0]          rom_addr,
  input  logic [DATA_LENGTH-1:0] rom_data,
  input  logic                   redirect_valid,
  input  logic [AW-1:0]          redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [DATA_LENGTH-1:0] instr_data,
  output logic [AW-1:0]          instr_pc
);

  localparam logic [AW-1:0] RST_PC  = AW'(RESET_PC);
  localparam logic [AW-1:0] LAST_PC = AW'(MEM_LENGTH - 1);

  logic [AW-1:0]                fetch_pc_q, fetch_pc_d;
  logic                         req_q, req_d;
  logic [AW-1:0]                req_pc_q, req_pc_d;
  logic [1:0]                   count_q, count_d;
  logic [1:0][DATA_LENGTH-1:0]  dat_q, dat_d;
  logic [1:0][AW-1:0]           pcs_q, pcs_d;

  logic       pop, issue, wr_idx;
  logic [2:0] occ;

  assign rom_addr    = fetch_pc_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr_data  = dat_q[0];
  assign instr_pc    = pcs_q[0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    dat_d      = dat_q;
    pcs_d      = pcs_q;

    pop   = instr_valid & instr_ready;
    // Occupancy counts the in-flight read so a full FIFO never gets a third word.
    occ   = {1'b0, count_q} + {2'b0, req_q} - {2'b0, pop};
    issue = !redirect_valid && (occ < 3'd2);
    // Tail slot after any same-cycle pop has shifted the head.
    wr_idx = (count_q == 2'd2) | ((count_q == 2'd1) & !pop);

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      req_d      = 1'b0;
      count_d    = 2'd0;
    end else begin
      req_d = issue;
      if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = (fetch_pc_q == LAST_PC) ? '0 : fetch_pc_q + AW'(1);
      end
      if (pop) begin
        dat_d[0] = dat_q[1];
        pcs_d[0] = pcs_q[1];
      end
      if (req_q) begin
        dat_d[wr_idx] = rom_data;
        pcs_d[wr_idx] = req_pc_q;
      end
      count_d = count_q + {1'b0, req_q} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RST_PC;
      req_q      <= 1'b0;
      req_pc_q   <= '0;
      count_q    <= 2'd0;
      dat_q      <= '0;
      pcs_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      dat_q      <= dat_d;
      pcs_q      <= pcs_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference of the fetch pipeline compared every
// cycle, plus directed literal checks for reset, stall, wrap, redirect and async reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [4:0]  instr_pc;

  logic [31:0] mem [32];
  int errs = 0;
  int checks = 0;

  fetch_unit #(.DATA_LENGTH(32), .MEM_LENGTH(32), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: queue of buffered pcs, one optional in-flight pc, next fetch pc.
  int mq[$];
  bit minf;
  int minf_pc;
  int mfetch;
  bit m_pop;
  int m_occ;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      minf = 0;
      mfetch = 0;
    end else begin
      m_pop = (mq.size() > 0) && instr_ready;
      if (redirect_valid) begin
        mq.delete();
        minf = 0;
        mfetch = int'(redirect_pc);
      end else begin
        m_occ = mq.size() + int'(minf) - int'(m_pop);
        if (m_pop) void'(mq.pop_front());
        if (minf) mq.push_back(minf_pc);
        if (m_occ < 2) begin
          minf = 1;
          minf_pc = mfetch;
          mfetch = (mfetch + 1) % 32;
        end else minf = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_valid", 32'(instr_valid), 32'(mq.size() > 0));
      chk("model_rom_addr", 32'(rom_addr), 32'(mfetch));
      if (mq.size() > 0) begin
        chk("model_pc", 32'(instr_pc), 32'(mq[0]));
        chk("model_data", instr_data, 32'h100 + 32'(mq[0]));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string nm, input int pc);
    chk({nm, "_valid"}, 32'(instr_valid), 32'd1);
    chk({nm, "_pc"}, 32'(instr_pc), 32'(pc));
    chk({nm, "_data"}, instr_data, 32'h100 + 32'(pc));
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #3;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_data", instr_data, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Streaming from reset: first valid after edge 1, no gaps.
    step;
    chk("edge0_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step;
      expect_head("stream", i);
    end

    // Stall from first valid for 5 cycles.
    do_reset;
    step;
    step;
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_head("stall", 0);
      step;
    end
    chk("stall_rom_addr", 32'(rom_addr), 32'd2);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_head("unstall", i);
      step;
    end

    // Redirect near the top: wraps 30,31,0,1.
    redirect_valid = 1'b1;
    redirect_pc = 5'd30;
    step;
    redirect_valid = 1'b0;
    chk("redir_n1_valid", 32'(instr_valid), 32'd0);
    step;
    step;
    for (int i = 0; i < 4; i++) begin
      expect_head("wrap", (30 + i) % 32);
      step;
    end

    // Redirect with a full FIFO.
    instr_ready = 1'b0;
    step; step; step;
    redirect_valid = 1'b1;
    redirect_pc = 5'd8;
    step;
    redirect_valid = 1'b0;
    chk("full_redir_valid", 32'(instr_valid), 32'd0);
    step;
    step;
    expect_head("full_redir", 8);
    step;
    step;

    // Redirect coincident with a pop; the second entry must vanish.
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 5'd20;
    step;
    redirect_valid = 1'b0;
    chk("pop_redir_valid", 32'(instr_valid), 32'd0);
    step;
    step;
    expect_head("pop_redir", 20);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = 5'($urandom_range(0, 31));
      step;
    end
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    step; step; step;

    // Asynchronous reset mid-cycle while streaming.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_rom_addr", 32'(rom_addr), 32'd0);
    chk("arst_pc", 32'(instr_pc), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step;
    step;
    expect_head("arst_restart", 0);
    step;
    expect_head("arst_restart", 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
